// File: rtl/sipo_pkg.sv
// Shared types and constants for the 4-bit serial-in/parallel-out deserializer.
// Bits arrive LSB first, which matches the bit order of the 4-bit PISO.
package sipo_pkg;

  localparam int WORD_W    = 4;
  localparam int CNT_W     = 8;
  localparam int BIT_CNT_W = 2;

  localparam logic [CNT_W-1:0]     WORD_CNT_INC = 'd1;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST     = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// 2-bit bit-position counter with synchronous clear, load-to-1 and increment.
// Priority order: rst, clr, load1, en.
module sipo_bit_counter
  import sipo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load1,
  input  logic                 en,
  output logic [BIT_CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= 2'd1;
    end else if (en) begin
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/sipo_4bit_deser.sv
// 4-bit deserializer: collects LSB-first serial bits framed by sof into words.
// All outputs are registered; a premature sof aborts the partial word.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no word in progress; only a bit with sof is accepted
//   RECV  | bit 0 captured, bits 1..3 pending (position in bit_cnt)
module sipo_4bit_deser
  import sipo_pkg::*;
#(
  parameter int WORD_W = sipo_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              ser_en,
  input  logic              sof,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  output logic              frame_err,
  output logic [CNT_W-1:0]  word_cnt
);

  state_t                 state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [WORD_W-2:0]      shift;  // bits 0..2; bit 3 goes straight into dout

  logic start;
  logic advance;
  logic last;
  logic cnt_clr;
  logic cnt_en;

  // sof restarts a word from either state, so the counter load ignores state
  assign start   = ser_en & sof;
  assign advance = ser_en & ~sof & (state == RECV);
  assign last    = (bit_cnt == BIT_LAST);
  assign cnt_clr = advance & last;
  assign cnt_en  = advance & ~last;

  sipo_bit_counter u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .load1 (start),
    .en    (cnt_en),
    .cnt   (bit_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      word_cnt   <= '0;
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (ser_en) begin
        case (state)
          IDLE: begin
            if (sof) begin
              shift <= {{(WORD_W-2){1'b0}}, ser_in};
              state <= RECV;
            end
          end
          RECV: begin
            if (sof) begin
              frame_err <= 1'b1;
              shift     <= {{(WORD_W-2){1'b0}}, ser_in};
            end else if (last) begin
              dout       <= {ser_in, shift};
              dout_valid <= 1'b1;
              word_cnt   <= word_cnt + WORD_CNT_INC;
              state      <= IDLE;
            end else begin
              shift[bit_cnt] <= ser_in;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/sipo_4bit_deser.md
SIPO_4BIT_DESER -- requirements
Module: sipo_4bit_deser

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, ports named clk and rst.
REQ-002 Parameter: WORD_W, default 4, deserialized word width; only 4 is supported.
REQ-003 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ser_in  in  1  serial data bit, LSB first (matches 4-bit PISO output order din[0]..din[3])
- ser_en  in  1  ser_in is valid this cycle
- sof  in  1  start-of-word; marks the current bit as bit 0; ignored when ser_en=0
- dout  out  4  last completed word
- dout_valid  out  1  one-cycle pulse; dout updated this cycle
- frame_err  out  1  one-cycle pulse; partial word aborted by premature sof
- word_cnt  out  8  count of completed words, wraps

Function
REQ-004 The FSM SHALL have two states: IDLE (no word in progress) and RECV (bits 1..3 pending); bit_cnt is 2 bits.
REQ-005 In IDLE with ser_en=1 and sof=1: store ser_in at shift[0], bit_cnt<=1, go to RECV.
REQ-006 In IDLE with ser_en=1 and sof=0: discard the bit; no state change; no pulse.
REQ-007 In RECV with ser_en=1 and sof=0: store ser_in at shift[bit_cnt], bit_cnt<=bit_cnt+1.
REQ-008 On the edge storing bit 3 (bit_cnt==3): dout<={ser_in,shift[2:0]}, dout_valid<=1, word_cnt<=word_cnt+1 (mod 256), go to IDLE.
REQ-009 Latency: dout and dout_valid SHALL be visible in the cycle after the edge that samples bit 3.
REQ-010 In RECV with ser_en=1 and sof=1 (premature):
- frame_err<=1 for one cycle
- discard partial bits
- take ser_in as bit 0 of a new word, bit_cnt<=1, stay in RECV
- word_cnt unchanged
REQ-011 With ser_en=0: state, bit_cnt and shift hold; gaps of any length between bits are legal.
REQ-012 Back-to-back words SHALL work: sof with ser_en in the cycle right after bit 3 starts a new word with no lost bit.
REQ-013 dout SHALL hold its value between completions; dout_valid and frame_err SHALL be zero except on their pulse cycles.
REQ-014 dout_valid and frame_err SHALL never both be 1 in the same cycle.

Reset
REQ-015 While rst=1 at a clk edge: state<=IDLE, bit_cnt<=0, shift<=0, dout<=0, dout_valid<=0, frame_err<=0, word_cnt<=0.
REQ-016 rst SHALL take priority over ser_en/sof.
REQ-017 Reset mid-word SHALL discard the partial word with no dout_valid and no frame_err.
REQ-018 The first bit accepted after reset release SHALL require sof.

Structure
REQ-019 A shared package sipo_pkg SHALL hold the state typedef (IDLE, RECV) and the constants WORD_W=4 and CNT_W=8.
REQ-020 One sub-module, sipo_bit_counter, SHALL be used: a 2-bit counter with synchronous clear, load-to-1 and enable.
REQ-021 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Verification
REQ-022 After reset, send bits 0,1,0,1 (sof on first, ser_en=1 continuous) -> dout=4'hA, dout_valid high 1 cycle later for 1 cycle, word_cnt=1.
REQ-023 Send 4'h3 then 4'hC back-to-back with no idle cycle -> two dout_valid pulses 4 cycles apart, dout=3 then C, word_cnt=2.
REQ-024 Send 2 bits, then sof with word 4'h5 -> frame_err pulse on the sof edge, then dout=5 with one dout_valid, word_cnt +1 only.
REQ-025 Send 4'h9 with ser_en=0 gaps of 1-3 cycles between bits; also send 2 bits without sof from IDLE -> dout=9; no-sof bits ignored.
REQ-026 Send 3 bits then assert rst for 1 cycle; then send 4'hF with sof -> no pulse during/after reset, dout=0 until F completes, word_cnt=1.
REQ-027 Send 256 words -> word_cnt wraps to 0 after the 256th dout_valid.
